decode_stage: RTL and testbench
===============================

# decode_stage

Registered, queued successor to the combinational instruction decoder. It sits between fetch and execute. It accepts instruction words with their PC over a valid/ready handshake and buffers them in a DEPTH-entry queue. It presents a registered control bundle to execute, adds illegal-instruction detection and flush, and keeps register-file and CSR data reads out of the decode path.

## Interface
Parameters:
- DEPTH, 2: instruction queue entries. Must be a power of two, at least 2.
- PC_WIDTH, 32: width of the PC carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  discard all queued and presented instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept one instruction.
- in_code  in  32  instruction word.
- in_pc  in  PC_WIDTH  PC of in_code.
- out_valid  out  1  decoded bundle is valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  PC_WIDTH  PC of the presented instruction.
- rs1_num, rs2_num, rd_num  out  5 each  register numbers; zero where the format has no such field.
- imm  out  32  sign- or zero-extended immediate for formats I, S, B, U and J.
- alu_op_sel  out  ALU_OP_WIDTH  ALU operation.
- src_a_sel  out  SEL_SRC_A_WIDTH  ALU operand A source.
- src_b_sel  out  SEL_SRC_B_WIDTH  ALU operand B source.
- pc_sel  out  SEL_PC_WIDTH  next-PC source.
- wb_reg  out  1  instruction writes the register file.
- wb_csr  out  1  instruction writes a CSR.
- csr_op  out  3  func3 of a SYSTEM/CSR instruction; 0 otherwise.
- illegal  out  1  instruction is not decodable.
- count  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- Push: an instruction is pushed when in_valid and in_ready are both high.
- in_ready = (count < DEPTH). It is registered-derived and never depends combinationally on out_ready.
- Output register: one bundle register sits after the queue. It loads when it is empty, or when out_valid and out_ready are both high.
  - Source is the queue head if the queue is non-empty.
  - Otherwise, with a push in the same cycle, the incoming instruction bypasses the queue and loads directly.
- Decode rules:
  - OP / OP-IMM, func3=101: func7 0000000 selects SRL, 0100000 selects SRA.
  - OP-IMM shifts (func3 001 and 101) with any other func7 are illegal.
  - BRANCH with func3 010 or 011 is illegal.
  - Any unlisted opcode is illegal.
- JALR uses operands PC and 4 (link value) and pc_sel JALR. JAL uses operands PC and 4 and pc_sel JAL.
- An illegal instruction still propagates with illegal=1 and wb_reg=wb_csr=0. All selects take their NONE codes and imm=0.
- CSR write-data is not computed here. Execute combines csr_op, rs1 data, zimm (rs1_num) and CSR read data.

## Timing
- Reset: out_valid=0, count=0 and every bundle field is 0 (illegal=0). in_ready=1 one cycle after reset release. Queue pointers are zeroed.
- Latency:
  - With the queue empty and the output register free, an instruction accepted at edge N has out_valid high after edge N.
  - With the queue non-empty, instructions leave in FIFO order, one per out_ready cycle.
- Hold: while out_valid=1 and out_ready=0, all outputs are held stable.
- Queue full: in_ready=0. A same-cycle pop does not admit a push; in_ready rises the cycle after.
- Queue empty while the output register drains: out_valid drops after the consuming edge.
- Pointers wrap modulo DEPTH. count is exact for every push/pop combination.
- Flush:
  - At the next edge, count=0 and out_valid=0.
  - A push offered in the flush cycle is dropped.
  - out_ready is ignored in the flush cycle.
  - Flush has priority over push and pop.
- Reset asserted mid-operation clears all state immediately, whatever the handshake state.

## Configuration
- DECODE_CSR_EN defined: opcode 1110011 with func3 in {001, 010, 011, 101, 110, 111} decodes with:
  - wb_csr=1 and csr_op=func3;
  - wb_reg=1 when rd≠0;
  - imm = CSR address, zero-extended.
- Without DECODE_CSR_EN, every SYSTEM opcode is illegal and wb_csr is tied 0.

## Structure
- Shared header / package:
  - ALU_OP_* and SEL_SRC_A_*, SEL_SRC_B_*, SEL_PC_* codes and widths;
  - RV32 opcode constants;
  - instruction-type codes (NONE, R, I, S, B, U, J).
- Sub-module decode_logic: a pure combinational decoder from code to the bundle fields plus illegal. It is instantiated once, on the mux output feeding the bundle register.
- The decode_stage top holds the queue, pointers, count, bypass mux and bundle register.

## Test plan
- addi x1,x0,5 (0x00500093) into an empty block -> next cycle:
  - out_valid=1, rd_num=1, rs1_num=0, imm=5;
  - alu ADD, src_b IMM, wb_reg=1, illegal=0.
- srai x2,x1,3 (0x4030D113), then srli (0x0030D113) -> alu_op_sel SRA then SRL. OP-IMM func3=101 with func7 0x7F -> illegal=1, wb_reg=0.
- lui x5,0x12345 (0x123452B7) -> imm=0x12345000, src_a IMM, src_b 0, rd_num=5.
- Backpressure: hold out_ready=0 and push DEPTH+1 instructions ->
  - in_ready drops after DEPTH+1 accepts (output register plus DEPTH);
  - count=DEPTH;
  - releasing out_ready drains all instructions in PC order without loss or duplication.
- Flush with count=2, out_valid=1 and a push offered in the same cycle -> next cycle: count=0, out_valid=0, and the offered instruction never appears.
- csrrw x1,0x300,x2 (0x300110F3) -> with DECODE_CSR_EN: wb_csr=1, csr_op=001, imm=0x300, wb_reg=1. Without DECODE_CSR_EN: illegal=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared codes, RV32 opcodes and the control bundle for decode_stage.
// Optional CSR decode is enabled by defining DECODE_CSR_EN.
package decode_stage_pkg;

    localparam int ALU_OP_WIDTH    = 4;
    localparam int SEL_SRC_A_WIDTH = 2;
    localparam int SEL_SRC_B_WIDTH = 3;
    localparam int SEL_PC_WIDTH    = 3;

    localparam logic [3:0] ALU_OP_NONE = 4'd0;
    localparam logic [3:0] ALU_OP_ADD  = 4'd1;
    localparam logic [3:0] ALU_OP_SUB  = 4'd2;
    localparam logic [3:0] ALU_OP_SLL  = 4'd3;
    localparam logic [3:0] ALU_OP_SLT  = 4'd4;
    localparam logic [3:0] ALU_OP_SLTU = 4'd5;
    localparam logic [3:0] ALU_OP_XOR  = 4'd6;
    localparam logic [3:0] ALU_OP_SRL  = 4'd7;
    localparam logic [3:0] ALU_OP_SRA  = 4'd8;
    localparam logic [3:0] ALU_OP_OR   = 4'd9;
    localparam logic [3:0] ALU_OP_AND  = 4'd10;

    localparam logic [1:0] SEL_SRC_A_NONE = 2'd0;
    localparam logic [1:0] SEL_SRC_A_REG  = 2'd1;
    localparam logic [1:0] SEL_SRC_A_PC   = 2'd2;
    localparam logic [1:0] SEL_SRC_A_IMM  = 2'd3;

    localparam logic [2:0] SEL_SRC_B_NONE = 3'd0;
    localparam logic [2:0] SEL_SRC_B_REG  = 3'd1;
    localparam logic [2:0] SEL_SRC_B_IMM  = 3'd2;
    localparam logic [2:0] SEL_SRC_B_FOUR = 3'd3;
    localparam logic [2:0] SEL_SRC_B_ZERO = 3'd4;

    localparam logic [2:0] SEL_PC_NONE   = 3'd0;
    localparam logic [2:0] SEL_PC_PLUS4  = 3'd1;
    localparam logic [2:0] SEL_PC_BRANCH = 3'd2;
    localparam logic [2:0] SEL_PC_JAL    = 3'd3;
    localparam logic [2:0] SEL_PC_JALR   = 3'd4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IT_NONE, IT_R, IT_I, IT_S, IT_B, IT_U, IT_J
    } itype_t;

    typedef struct packed {
        logic [4:0]                 rs1_num;
        logic [4:0]                 rs2_num;
        logic [4:0]                 rd_num;
        logic [31:0]                imm;
        logic [ALU_OP_WIDTH-1:0]    alu_op_sel;
        logic [SEL_SRC_A_WIDTH-1:0] src_a_sel;
        logic [SEL_SRC_B_WIDTH-1:0] src_b_sel;
        logic [SEL_PC_WIDTH-1:0]    pc_sel;
        logic                       wb_reg;
        logic                       wb_csr;
        logic [2:0]                 csr_op;
        logic                       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic [31:0] imm_gen(input logic [31:0] c,
                                            input itype_t t);
        case (t)
            IT_I: imm_gen = {{20{c[31]}}, c[31:20]};
            IT_S: imm_gen = {{20{c[31]}}, c[31:25], c[11:7]};
            IT_B: imm_gen = {{19{c[31]}}, c[31], c[7],
                             c[30:25], c[11:8], 1'b0};
            IT_U: imm_gen = {c[31:12], 12'b0};
            IT_J: imm_gen = {{11{c[31]}}, c[31], c[19:12],
                             c[20], c[30:21], 1'b0};
            default: imm_gen = 32'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3,
                                          input logic alt);
        case (f3)
            3'b000: alu_of = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001: alu_of = ALU_OP_SLL;
            3'b010: alu_of = ALU_OP_SLT;
            3'b011: alu_of = ALU_OP_SLTU;
            3'b100: alu_of = ALU_OP_XOR;
            3'b101: alu_of = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110: alu_of = ALU_OP_OR;
            default: alu_of = ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Pure combinational RV32I decoder producing the control bundle.
// SYSTEM/CSR forms decode only when DECODE_CSR_EN is defined.
module decode_logic
    import decode_stage_pkg::*;
(
    input  logic [31:0]       code,
    output logic [CTRL_W-1:0] ctrl
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    itype_t     itype;
    ctrl_t      c;
    logic       bad;
    logic       csr;

    assign opcode = code[6:0];
    assign func3  = code[14:12];
    assign func7  = code[31:25];
    assign ctrl   = c;

    always_comb begin
        c        = '0;
        itype    = IT_NONE;
        bad      = 1'b0;
        csr      = 1'b0;
        c.pc_sel = SEL_PC_PLUS4;
        unique case (1'b1)
            (opcode == OPC_LUI): begin
                itype        = IT_U;
                c.alu_op_sel = ALU_OP_ADD;
                c.src_a_sel  = SEL_SRC_A_IMM;
                c.src_b_sel  = SEL_SRC_B_ZERO;
                c.wb_reg     = 1'b1;
            end
            (opcode == OPC_AUIPC): begin
                itype        = IT_U;
                c.alu_op_sel = ALU_OP_ADD;
                c.src_a_sel  = SEL_SRC_A_PC;
                c.src_b_sel  = SEL_SRC_B_IMM;
                c.wb_reg     = 1'b1;
            end
            (opcode == OPC_JAL): begin
                itype        = IT_J;
                c.alu_op_sel = ALU_OP_ADD;
                c.src_a_sel  = SEL_SRC_A_PC;
                c.src_b_sel  = SEL_SRC_B_FOUR;
                c.pc_sel     = SEL_PC_JAL;
                c.wb_reg     = 1'b1;
            end
            (opcode == OPC_JALR): begin
                itype        = IT_I;
                bad          = (func3 != 3'b000);
                c.alu_op_sel = ALU_OP_ADD;
                c.src_a_sel  = SEL_SRC_A_PC;
                c.src_b_sel  = SEL_SRC_B_FOUR;
                c.pc_sel     = SEL_PC_JALR;
                c.wb_reg     = 1'b1;
            end
            (opcode == OPC_BRANCH): begin
                itype        = IT_B;
                bad          = (func3[2:1] == 2'b01);
                c.alu_op_sel = !func3[2] ? ALU_OP_SUB :
                               func3[1] ? ALU_OP_SLTU : ALU_OP_SLT;
                c.src_a_sel  = SEL_SRC_A_REG;
                c.src_b_sel  = SEL_SRC_B_REG;
                c.pc_sel     = SEL_PC_BRANCH;
            end
            (opcode == OPC_LOAD): begin
                itype        = IT_I;
                bad          = (func3 == 3'b011) || (func3[2:1] == 2'b11);
                c.alu_op_sel = ALU_OP_ADD;
                c.src_a_sel  = SEL_SRC_A_REG;
                c.src_b_sel  = SEL_SRC_B_IMM;
                c.wb_reg     = 1'b1;
            end
            (opcode == OPC_STORE): begin
                itype        = IT_S;
                bad          = func3[2] || (func3 == 3'b011);
                c.alu_op_sel = ALU_OP_ADD;
                c.src_a_sel  = SEL_SRC_A_REG;
                c.src_b_sel  = SEL_SRC_B_IMM;
            end
            (opcode == OPC_OP_IMM): begin
                itype = IT_I;
                if (func3 == 3'b001)
                    bad = (func7 != 7'b0000000);
                if (func3 == 3'b101)
                    bad = (func7 != 7'b0000000) && (func7 != 7'b0100000);
                c.alu_op_sel = alu_of(func3, (func3 == 3'b101) && func7[5]);
                c.src_a_sel  = SEL_SRC_A_REG;
                c.src_b_sel  = SEL_SRC_B_IMM;
                c.wb_reg     = 1'b1;
            end
            (opcode == OPC_OP): begin
                itype = IT_R;
                bad   = !((func7 == 7'b0000000) ||
                          ((func7 == 7'b0100000) &&
                           ((func3 == 3'b000) || (func3 == 3'b101))));
                c.alu_op_sel = alu_of(func3, func7[5]);
                c.src_a_sel  = SEL_SRC_A_REG;
                c.src_b_sel  = SEL_SRC_B_REG;
                c.wb_reg     = 1'b1;
            end
            (opcode == OPC_FENCE): begin
                itype = IT_NONE;
            end
`ifdef DECODE_CSR_EN
            (opcode == OPC_SYSTEM): begin
                bad      = (func3 == 3'b000) || (func3 == 3'b100);
                csr      = 1'b1;
                c.wb_csr = 1'b1;
                c.csr_op = func3;
                c.wb_reg = (code[11:7] != 5'd0);
            end
`endif
            default: bad = 1'b1;
        endcase

        c.imm = imm_gen(code, itype);
        case (itype)
            IT_R: begin
                c.rs1_num = code[19:15];
                c.rs2_num = code[24:20];
                c.rd_num  = code[11:7];
            end
            IT_I: begin
                c.rs1_num = code[19:15];
                c.rd_num  = code[11:7];
            end
            IT_S, IT_B: begin
                c.rs1_num = code[19:15];
                c.rs2_num = code[24:20];
            end
            IT_U, IT_J: c.rd_num = code[11:7];
            default: ;
        endcase

        // rs1_num doubles as zimm for the immediate CSR forms
        if (csr) begin
            c.imm     = {20'b0, code[31:20]};
            c.rs1_num = code[19:15];
            c.rd_num  = code[11:7];
        end

        if (bad) begin
            c         = '0;
            c.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Queued decode stage: FIFO of fetched words plus a registered control bundle.
// Define DECODE_CSR_EN to decode Zicsr instructions.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_code,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [4:0]                 rs1_num,
    output logic [4:0]                 rs2_num,
    output logic [4:0]                 rd_num,
    output logic [31:0]                imm,
    output logic [ALU_OP_WIDTH-1:0]    alu_op_sel,
    output logic [SEL_SRC_A_WIDTH-1:0] src_a_sel,
    output logic [SEL_SRC_B_WIDTH-1:0] src_b_sel,
    output logic [SEL_PC_WIDTH-1:0]    pc_sel,
    output logic                       wb_reg,
    output logic                       wb_csr,
    output logic [2:0]                 csr_op,
    output logic                       illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]         code_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       cnt;
    logic                vld;
    ctrl_t               bundle;
    logic [PC_WIDTH-1:0] pc_r;

    logic                empty;
    logic                push;
    logic                load;
    logic                pop;
    logic                bypass;
    logic                wr;
    logic [31:0]         sel_code;
    logic [PC_WIDTH-1:0] sel_pc;
    logic [CTRL_W-1:0]   dec_bits;
    ctrl_t               dec;

    assign empty  = (cnt == '0);
    assign in_ready = (cnt < FULL);
    assign push   = in_valid && in_ready;
    // the bundle register refills when empty or being consumed
    assign load   = !flush && (!vld || out_ready);
    assign pop    = load && !empty;
    assign bypass = load && empty && push;
    assign wr     = push && !flush && !bypass;

    assign sel_code = empty ? in_code : code_mem[rd_ptr];
    assign sel_pc   = empty ? in_pc : pc_mem[rd_ptr];

    decode_logic u_decode (
        .code (sel_code),
        .ctrl (dec_bits)
    );

    assign dec = dec_bits;

    always_ff @(posedge clk) begin
        if (wr) begin
            code_mem[wr_ptr] <= in_code;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= 1'b0;
            bundle <= '0;
            pc_r   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
            if (load) begin
                vld <= !empty || push;
                if (!empty || push) begin
                    bundle <= dec;
                    pc_r   <= sel_pc;
                end
            end
        end
    end

    assign out_valid  = vld;
    assign count      = cnt;
    assign out_pc     = pc_r;
    assign rs1_num    = bundle.rs1_num;
    assign rs2_num    = bundle.rs2_num;
    assign rd_num     = bundle.rd_num;
    assign imm        = bundle.imm;
    assign alu_op_sel = bundle.alu_op_sel;
    assign src_a_sel  = bundle.src_a_sel;
    assign src_b_sel  = bundle.src_b_sel;
    assign pc_sel     = bundle.pc_sel;
    assign wb_reg     = bundle.wb_reg;
    assign wb_csr     = bundle.wb_csr;
    assign csr_op     = bundle.csr_op;
    assign illegal    = bundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: decode fields, queueing, flush, reset.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_code;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs1_num;
    logic [4:0]  rs2_num;
    logic [4:0]  rd_num;
    logic [31:0] imm;
    logic [ALU_OP_WIDTH-1:0]    alu_op_sel;
    logic [SEL_SRC_A_WIDTH-1:0] src_a_sel;
    logic [SEL_SRC_B_WIDTH-1:0] src_b_sel;
    logic [SEL_PC_WIDTH-1:0]    pc_sel;
    logic        wb_reg;
    logic        wb_csr;
    logic [2:0]  csr_op;
    logic        illegal;
    logic [1:0]  count;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb_pc [$];
    logic [4:0]  sb_rd [$];
    logic [31:0] exp_pc;
    logic [4:0]  exp_rd;

    always #5 clk = ~clk;

    decode_stage #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .rs1_num    (rs1_num),
        .rs2_num    (rs2_num),
        .rd_num     (rd_num),
        .imm        (imm),
        .alu_op_sel (alu_op_sel),
        .src_a_sel  (src_a_sel),
        .src_b_sel  (src_b_sel),
        .pc_sel     (pc_sel),
        .wb_reg     (wb_reg),
        .wb_csr     (wb_csr),
        .csr_op     (csr_op),
        .illegal    (illegal),
        .count      (count)
    );

    function automatic logic [31:0] addi_code(input int v, input int rd);
        addi_code = {12'(v), 5'd0, 3'b000, 5'(rd), 7'b0010011};
    endfunction

    // push expectation, offer one word for one edge (in_ready assumed high)
    task automatic send(input logic [31:0] code, input logic [31:0] pc,
                        input logic [4:0] rd);
        sb_pc.push_back(pc);
        sb_rd.push_back(rd);
        in_valid = 1'b1;
        in_code  = code;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_code = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            failures++;
            $display("FAIL reset_state out_valid=%b count=%0d want 0/0",
                     out_valid, count);
        end
        checks++;
        if (imm !== 32'd0 || illegal !== 1'b0 || alu_op_sel !== '0 ||
            out_pc !== 32'd0 || wb_reg !== 1'b0) begin
            failures++;
            $display("FAIL reset_bundle imm=%h illegal=%b alu=%0d want zeros",
                     imm, illegal, alu_op_sel);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_addi();
        send(32'h00500093, 32'h1000, 5'd1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL addi_latency out_valid=%b want=1", out_valid);
        end
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (out_pc !== exp_pc || rd_num !== exp_rd || rs1_num !== 5'd0) begin
            failures++;
            $display("FAIL addi_regs pc=%h rd=%0d rs1=%0d want %h/%0d/0",
                     out_pc, rd_num, rs1_num, exp_pc, exp_rd);
        end
        checks++;
        if (imm !== 32'd5 || alu_op_sel !== ALU_OP_ADD ||
            src_b_sel !== SEL_SRC_B_IMM || wb_reg !== 1'b1 ||
            illegal !== 1'b0) begin
            failures++;
            $display("FAIL addi_ctrl imm=%0d alu=%0d b=%0d wb=%b ill=%b",
                     imm, alu_op_sel, src_b_sel, wb_reg, illegal);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || imm !== 32'd5 || out_pc !== exp_pc) begin
            failures++;
            $display("FAIL addi_hold valid=%b imm=%0d pc=%h want 1/5/%h",
                     out_valid, imm, out_pc, exp_pc);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL addi_drain out_valid=%b want=0", out_valid);
        end
    endtask

    task automatic test_shifts();
        send(32'h4030D113, 32'h1004, 5'd2);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (alu_op_sel !== ALU_OP_SRA || rs1_num !== 5'd1 ||
            rd_num !== exp_rd || out_pc !== exp_pc) begin
            failures++;
            $display("FAIL srai alu=%0d rs1=%0d rd=%0d want SRA/1/%0d",
                     alu_op_sel, rs1_num, rd_num, exp_rd);
        end
        consume();
        send(32'h0030D113, 32'h1008, 5'd2);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (alu_op_sel !== ALU_OP_SRL || out_pc !== exp_pc) begin
            failures++;
            $display("FAIL srli alu=%0d pc=%h want SRL/%h",
                     alu_op_sel, out_pc, exp_pc);
        end
        consume();
        send(32'hFE00D113, 32'h100C, 5'd0);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (illegal !== 1'b1 || wb_reg !== 1'b0 || imm !== 32'd0 ||
            alu_op_sel !== ALU_OP_NONE || src_a_sel !== SEL_SRC_A_NONE ||
            out_valid !== 1'b1 || out_pc !== exp_pc) begin
            failures++;
            $display("FAIL shift_bad_func7 ill=%b wb=%b imm=%h alu=%0d",
                     illegal, wb_reg, imm, alu_op_sel);
        end
        consume();
    endtask

    task automatic test_lui_jal();
        send(32'h123452B7, 32'h1010, 5'd5);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (imm !== 32'h12345000 || src_a_sel !== SEL_SRC_A_IMM ||
            src_b_sel !== SEL_SRC_B_ZERO || rd_num !== exp_rd ||
            wb_reg !== 1'b1) begin
            failures++;
            $display("FAIL lui imm=%h a=%0d b=%0d rd=%0d want 12345000/IMM/ZERO/5",
                     imm, src_a_sel, src_b_sel, rd_num);
        end
        consume();
        send(32'h008000EF, 32'h1014, 5'd1);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (imm !== 32'd8 || src_a_sel !== SEL_SRC_A_PC ||
            src_b_sel !== SEL_SRC_B_FOUR || pc_sel !== SEL_PC_JAL ||
            rd_num !== exp_rd) begin
            failures++;
            $display("FAIL jal imm=%0d a=%0d b=%0d pc_sel=%0d rd=%0d",
                     imm, src_a_sel, src_b_sel, pc_sel, rd_num);
        end
        consume();
        send(32'h00002063, 32'h1018, 5'd0);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (illegal !== 1'b1 || pc_sel !== SEL_PC_NONE) begin
            failures++;
            $display("FAIL branch_f3_010 ill=%b pc_sel=%0d want 1/NONE",
                     illegal, pc_sel);
        end
        consume();
    endtask

    task automatic test_csr();
        send(32'h300110F3, 32'h101C, 5'd1);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
`ifdef DECODE_CSR_EN
        checks++;
        if (wb_csr !== 1'b1 || csr_op !== 3'b001 || imm !== 32'h300 ||
            wb_reg !== 1'b1 || illegal !== 1'b0 || rs1_num !== 5'd2) begin
            failures++;
            $display("FAIL csrrw wb_csr=%b op=%0d imm=%h wb=%b ill=%b",
                     wb_csr, csr_op, imm, wb_reg, illegal);
        end
`else
        checks++;
        if (illegal !== 1'b1 || wb_csr !== 1'b0 || wb_reg !== 1'b0) begin
            failures++;
            $display("FAIL csrrw_disabled ill=%b wb_csr=%b wb=%b want 1/0/0",
                     illegal, wb_csr, wb_reg);
        end
`endif
        consume();
    endtask

    task automatic test_backpressure();
        int got;
        logic acc;
        got = 0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid = 1'b1;
            in_code  = addi_code(i, i + 1);
            in_pc    = 32'h2000 + 32'(4 * i);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_accept%0d in_ready=%b want=1", i, in_ready);
            end else begin
                sb_pc.push_back(in_pc);
                sb_rd.push_back(5'(i + 1));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || count !== 2'(DEPTH) || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full in_ready=%b count=%0d valid=%b want 0/%0d/1",
                     in_ready, count, out_valid, DEPTH);
        end
        // pop edge while full: the extra offer must not get in
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = addi_code(99, 31);
        in_pc     = 32'h0000DEA0;
        for (int cyc = 0; cyc < 4 * DEPTH + 10; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb_pc.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra_out pc=%h want none", out_pc);
                end else begin
                    exp_pc = sb_pc.pop_front();
                    exp_rd = sb_rd.pop_front();
                    if (out_pc !== exp_pc || rd_num !== exp_rd) begin
                        failures++;
                        $display("FAIL bp_order pc=%h rd=%0d want %h/%0d",
                                 out_pc, rd_num, exp_pc, exp_rd);
                    end
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                sb_pc.push_back(in_pc);
                sb_rd.push_back(5'd31);
            end
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                checks++;
                if (count !== 2'(DEPTH - 1) || in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_pop_no_push count=%0d in_ready=%b want %0d/1",
                             count, in_ready, DEPTH - 1);
                end
                in_valid = 1'b0;
            end
            if (sb_pc.size() == 0 && !out_valid)
                break;
        end
        out_ready = 1'b0;
        checks++;
        if (got != DEPTH + 1 || sb_pc.size() != 0) begin
            failures++;
            $display("FAIL bp_drain got=%0d left=%0d want %0d/0",
                     got, sb_pc.size(), DEPTH + 1);
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        int got;
        logic acc;
        idx = 0;
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            in_valid = (idx < 8);
            in_code  = addi_code(idx, idx + 3);
            in_pc    = 32'h4000 + 32'(4 * idx);
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb_pc.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra pc=%h want none", out_pc);
                end else begin
                    exp_pc = sb_pc.pop_front();
                    exp_rd = sb_rd.pop_front();
                    if (out_pc !== exp_pc || rd_num !== exp_rd) begin
                        failures++;
                        $display("FAIL b2b_order pc=%h rd=%0d want %h/%0d",
                                 out_pc, rd_num, exp_pc, exp_rd);
                    end
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                sb_pc.push_back(in_pc);
                sb_rd.push_back(5'(idx + 3));
            end
            @(posedge clk);
            #1;
            if (acc)
                idx++;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != 8 || sb_pc.size() != 0) begin
            failures++;
            $display("FAIL b2b_total got=%0d left=%0d want 8/0",
                     got, sb_pc.size());
        end
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b0;
        send(addi_code(1, 1), 32'h5000, 5'd1);
        send(addi_code(2, 2), 32'h5004, 5'd2);
        send(addi_code(3, 3), 32'h5008, 5'd3);
        checks++;
        if (count !== 2'd2 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup count=%0d valid=%b want 2/1",
                     count, out_valid);
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_code = addi_code(7, 7); in_pc = 32'h0000BAD0;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        sb_pc.delete();
        sb_rd.delete();
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_full count=%0d valid=%b want 0/0",
                     count, out_valid);
        end
        send(addi_code(4, 4), 32'h5010, 5'd4);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_code = addi_code(8, 8); in_pc = 32'h0000BAD4;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sb_pc.delete();
        sb_rd.delete();
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_push_drop count=%0d valid=%b want 0/0",
                     count, out_valid);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid)
                seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_ghost seen=%0d want=0", seen);
        end
        send(addi_code(5, 9), 32'h5020, 5'd9);
        exp_pc = sb_pc.pop_front();
        exp_rd = sb_rd.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_pc || rd_num !== exp_rd) begin
            failures++;
            $display("FAIL flush_recover valid=%b pc=%h want 1/%h",
                     out_valid, out_pc, exp_pc);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(addi_code(1, 1), 32'h6000, 5'd1);
        send(addi_code(2, 2), 32'h6004, 5'd2);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || imm !== 32'd0) begin
            failures++;
            $display("FAIL reset_async count=%0d valid=%b imm=%h want 0/0/0",
                     count, out_valid, imm);
        end
        sb_pc.delete();
        sb_rd.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b valid=%b want 1/0",
                     in_ready, out_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_shifts();
        test_lui_jal();
        test_csr();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
